// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-bit shift sequencer: FSM states,
// shift-operation encodings, default widths and the fixed-point test
// used by the optional early-exit build (SHIFT_SEQ_EARLY_EXIT_EN).
package shift_sequencer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int AMT_W_DEF  = 4;

    typedef logic [1:0] shift_op_t;

    localparam shift_op_t SH_PASS = 2'b00;
    localparam shift_op_t SH_LSL  = 2'b01;
    localparam shift_op_t SH_LSR  = 2'b10;
    localparam shift_op_t SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // A value that further 1-bit steps cannot change: all-zero is stable
    // under every shift, all-ones is stable under ASR only.
    function automatic logic is_fixed_point(input logic [DATA_W_DEF-1:0] value,
                                            input shift_op_t             op);
        logic fixed;
        fixed = 1'b0;
        if (value == '0) begin
            fixed = 1'b1;
        end else if ((op == SH_ASR) && (value == '1)) begin
            fixed = 1'b1;
        end
        return fixed;
    endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step datapath shifter: moves the operand by exactly one bit
// (or passes it through). Purely combinational; the sequencer iterates it.
module shift_sequencer_shifter
    import shift_sequencer_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] in_data,
    input  shift_op_t    op,
    output logic [W-1:0] out_data
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic lsl_bit;
            logic lsr_bit;
            logic asr_bit;

            // LSL pulls from the next lower bit; bit 0 fills with zero.
            if (gi == 0) begin : g_lsb
                assign lsl_bit = 1'b0;
            end else begin : g_not_lsb
                assign lsl_bit = in_data[gi-1];
            end

            // LSR/ASR pull from the next higher bit; the MSB fills with
            // zero (LSR) or replicates the sign (ASR).
            if (gi == W-1) begin : g_msb
                assign lsr_bit = 1'b0;
                assign asr_bit = in_data[W-1];
            end else begin : g_not_msb
                assign lsr_bit = in_data[gi+1];
                assign asr_bit = in_data[gi+1];
            end

            assign out_data[gi] = (op == SH_LSL) ? lsl_bit :
                                  (op == SH_LSR) ? lsr_bit :
                                  (op == SH_ASR) ? asr_bit :
                                                   in_data[gi];
        end
    endgenerate

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller. Captures an operand, op and amount on an
// accepted start, then runs the 1-bit shifter once per clock until the
// amount is consumed, pulsing done with the registered result.
// Optional build macro: SHIFT_SEQ_EARLY_EXIT_EN -- leave SHIFT as soon as
// the working value reaches a fixed point (0x0000, or 0xFFFF under ASR).
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        shift_op,
    input  logic [AMT_W-1:0]  amount,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_e            state_q,  state_d;
    logic [DATA_W-1:0] work_q,   work_d;
    shift_op_t         op_q,     op_d;
    logic [AMT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q,   done_d;
    logic              ready_q,  ready_d;
    logic              busy_q,   busy_d;

    logic [DATA_W-1:0] shift_out;

    shift_sequencer_shifter #(
        .W (DATA_W)
    ) u_shifter (
        .in_data  (work_q),
        .op       (op_q),
        .out_data (shift_out)
    );

    // Next-state logic: FSM transitions, working register, countdown and
    // result capture; status outputs are derived from the next state so
    // they are registered alongside it.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        op_d     = op_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = in_data;
                    op_d    = shift_op;
                    count_d = amount;
                    if ((shift_op == SH_PASS) || (amount == '0)) begin
                        state_d  = DONE;
                        result_d = in_data;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d  = shift_out;
                count_d = count_q - AMT_W'(1);
                // Leaving at count==1 means count never reaches zero here,
                // so it cannot wrap even for the maximum amount.
                if (count_q == AMT_W'(1)) begin
                    state_d  = DONE;
                    result_d = shift_out;
                end
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                else if (is_fixed_point(shift_out, op_q)) begin
                    state_d  = DONE;
                    result_d = shift_out;
                    count_d  = '0;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            op_q     <= SH_PASS;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            op_q     <= op_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
